smep_smap_pipe: RTL and testbench

Registered, multi-port SMEP/SMAP permission checker. It is the parametrised successor to the single-lane combinational checker and sits between the TLB lookup stage and the fault/exception unit. It checks NUM_PORTS translated accesses per cycle with one cycle of latency. It also owns the architectural AC (SMAP-override) flag, which STAC/CLAC set and clear. It latches a first-fault syndrome for the trap handler and keeps saturating per-cause fault counters for performance monitoring.

---
 rtl/smep_smap_pkg.sv | 30 +++
 rtl/smep_smap_lane.sv | 26 ++
 rtl/smep_smap_pipe.sv | 156 +++++++++++++++
 tb/tb_smep_smap_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/smep_smap_pkg.sv
// Shared types and helpers for the SMEP/SMAP permission checker.
package smep_smap_pkg;

  localparam int unsigned SYN_PORT_W = 3;
  localparam int unsigned SYN_VA_W   = 64;

  typedef enum logic {
    CAUSE_SMEP = 1'b0,
    CAUSE_SMAP = 1'b1
  } cause_e;

  typedef struct packed {
    logic [SYN_PORT_W-1:0] port;
    logic [SYN_VA_W-1:0]   va;
    cause_e                cause;
  } syndrome_t;

  // Saturating add; max is the all-ones value of the destination counter.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/smep_smap_lane.sv
// Combinational SMEP/SMAP fault and cause evaluation for one check lane.
module smep_smap_lane
  import smep_smap_pkg::*;
(
  input  logic   valid_i,
  input  logic   kernel_i,
  input  logic   user_page_i,
  input  logic   exec_i,
  input  logic   smep_en_i,
  input  logic   smap_en_i,
  input  logic   ac_i,
  output logic   smep_c_o,
  output logic   smap_c_o,
  output logic   fault_c_o,
  output cause_e cause_c_o
);

  logic sup_user;

  assign sup_user  = valid_i & kernel_i & user_page_i;
  assign smep_c_o  = sup_user & exec_i & smep_en_i;
  assign smap_c_o  = sup_user & ~exec_i & smap_en_i & ~ac_i;
  assign fault_c_o = smep_c_o | smap_c_o;
  assign cause_c_o = smap_c_o ? CAUSE_SMAP : CAUSE_SMEP;

endmodule

// File: rtl/smep_smap_pipe.sv
// Registered multi-lane SMEP/SMAP checker with AC flag, first-fault syndrome
// and saturating per-cause fault counters.
module smep_smap_pipe
  import smep_smap_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned VA_W      = 48,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned PID_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_PORTS-1:0]      req_valid_i,
  input  logic [NUM_PORTS-1:0]      req_kernel_i,
  input  logic [NUM_PORTS-1:0]      req_user_page_i,
  input  logic [NUM_PORTS-1:0]      req_exec_i,
  input  logic [NUM_PORTS*VA_W-1:0] req_va_i,
  input  logic                      smep_en_i,
  input  logic                      smap_en_i,
  input  logic                      stac_i,
  input  logic                      clac_i,
  output logic                      ac_o,
  output logic [NUM_PORTS-1:0]      rsp_valid_o,
  output logic [NUM_PORTS-1:0]      rsp_fault_o,
  output logic                      syn_valid_o,
  output logic [PID_W-1:0]          syn_port_o,
  output logic [VA_W-1:0]           syn_va_o,
  output logic                      syn_cause_o,
  output logic                      syn_ovf_o,
  input  logic                      syn_clear_i,
  output logic [CNT_W-1:0]          smep_cnt_o,
  output logic [CNT_W-1:0]          smap_cnt_o,
  input  logic                      cnt_clear_i
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [NUM_PORTS-1:0] smep_c, smap_c, fault_c;
  cause_e               cause_c [NUM_PORTS];

  logic                 ac_d, ac_q;
  logic [NUM_PORTS-1:0] rsp_valid_q, rsp_fault_q;
  logic                 syn_valid_d, syn_valid_q;
  logic                 syn_ovf_d, syn_ovf_q;
  syndrome_t            syn_d, syn_q;
  logic [CNT_W-1:0]     smep_cnt_d, smep_cnt_q;
  logic [CNT_W-1:0]     smap_cnt_d, smap_cnt_q;

  logic                 any_fault;
  syndrome_t            cap;
  logic [31:0]          n_fault, n_smep, n_smap;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    smep_smap_lane u_lane (
      .valid_i     (req_valid_i[g]),
      .kernel_i    (req_kernel_i[g]),
      .user_page_i (req_user_page_i[g]),
      .exec_i      (req_exec_i[g]),
      .smep_en_i   (smep_en_i),
      .smap_en_i   (smap_en_i),
      .ac_i        (ac_q),
      .smep_c_o    (smep_c[g]),
      .smap_c_o    (smap_c[g]),
      .fault_c_o   (fault_c[g]),
      .cause_c_o   (cause_c[g])
    );
  end

  // Lowest-index fault selection and per-cause popcounts.
  always_comb begin
    any_fault = 1'b0;
    cap       = '0;
    n_fault   = '0;
    n_smep    = '0;
    n_smap    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (fault_c[p] && !any_fault) begin
        any_fault = 1'b1;
        cap.port  = SYN_PORT_W'(p);
        cap.va    = SYN_VA_W'(req_va_i[p*VA_W +: VA_W]);
        cap.cause = cause_c[p];
      end
      n_fault = n_fault + 32'(fault_c[p]);
      n_smep  = n_smep + 32'(smep_c[p]);
      n_smap  = n_smap + 32'(smap_c[p]);
    end
  end

  // AC flag, syndrome and counter next state; CLAC wins over STAC.
  always_comb begin
    ac_d        = ac_q;
    syn_valid_d = syn_valid_q;
    syn_ovf_d   = syn_ovf_q;
    syn_d       = syn_q;
    if (clac_i) begin
      ac_d = 1'b0;
    end else if (stac_i) begin
      ac_d = 1'b1;
    end

    if (!syn_valid_q || syn_clear_i) begin
      if (any_fault) begin
        syn_valid_d = 1'b1;
        syn_d       = cap;
        syn_ovf_d   = (n_fault > 32'd1);
      end else if (syn_clear_i) begin
        syn_valid_d = 1'b0;
        syn_ovf_d   = 1'b0;
        syn_d       = '0;
      end
    end else if (any_fault) begin
      syn_ovf_d = 1'b1;
    end

    smep_cnt_d = CNT_W'(sat_add(cnt_clear_i ? 32'd0 : 32'(smep_cnt_q), n_smep, CNT_MAX));
    smap_cnt_d = CNT_W'(sat_add(cnt_clear_i ? 32'd0 : 32'(smap_cnt_q), n_smap, CNT_MAX));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ac_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_fault_q <= '0;
      syn_valid_q <= 1'b0;
      syn_ovf_q   <= 1'b0;
      syn_q       <= '0;
      smep_cnt_q  <= '0;
      smap_cnt_q  <= '0;
    end else begin
      ac_q        <= ac_d;
      rsp_valid_q <= req_valid_i;
      rsp_fault_q <= fault_c;
      syn_valid_q <= syn_valid_d;
      syn_ovf_q   <= syn_ovf_d;
      syn_q       <= syn_d;
      smep_cnt_q  <= smep_cnt_d;
      smap_cnt_q  <= smap_cnt_d;
    end
  end

  assign ac_o        = ac_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_fault_o = rsp_fault_q;
  assign syn_valid_o = syn_valid_q;
  assign syn_ovf_o   = syn_ovf_q;
  assign syn_port_o  = syn_q.port[PID_W-1:0];
  assign syn_va_o    = syn_q.va[VA_W-1:0];
  assign syn_cause_o = syn_q.cause;
  assign smep_cnt_o  = smep_cnt_q;
  assign smap_cnt_o  = smap_cnt_q;

  // Upper syndrome bits beyond the configured widths are always zero.
  logic unused_syn;
  assign unused_syn = ^{syn_q.port >> PID_W, syn_q.va >> VA_W};

endmodule

// File: tb/tb_smep_smap_pipe.sv
// Directed self-checking bench for smep_smap_pipe (2 lanes, 2-bit counters).
module tb_smep_smap_pipe;

  localparam int unsigned NP = 2;
  localparam int unsigned VW = 48;
  localparam int unsigned CW = 2;

  logic             clk, rst_n;
  logic [NP-1:0]    req_valid, req_kernel, req_user, req_exec;
  logic [NP*VW-1:0] req_va;
  logic             smep_en, smap_en, stac, clac, syn_clear, cnt_clear;
  logic             ac, syn_valid, syn_cause, syn_ovf;
  logic [NP-1:0]    rsp_valid, rsp_fault;
  logic [0:0]       syn_port;
  logic [VW-1:0]    syn_va;
  logic [CW-1:0]    smep_cnt, smap_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  smep_smap_pipe #(.NUM_PORTS(NP), .VA_W(VW), .CNT_W(CW)) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_kernel_i    (req_kernel),
    .req_user_page_i (req_user),
    .req_exec_i      (req_exec),
    .req_va_i        (req_va),
    .smep_en_i       (smep_en),
    .smap_en_i       (smap_en),
    .stac_i          (stac),
    .clac_i          (clac),
    .ac_o            (ac),
    .rsp_valid_o     (rsp_valid),
    .rsp_fault_o     (rsp_fault),
    .syn_valid_o     (syn_valid),
    .syn_port_o      (syn_port),
    .syn_va_o        (syn_va),
    .syn_cause_o     (syn_cause),
    .syn_ovf_o       (syn_ovf),
    .syn_clear_i     (syn_clear),
    .smep_cnt_o      (smep_cnt),
    .smap_cnt_o      (smap_cnt),
    .cnt_clear_i     (cnt_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    req_valid = '0; req_kernel = '0; req_user = '0; req_exec = '0; req_va = '0;
    stac = 1'b0; clac = 1'b0; syn_clear = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic k, input logic u, input logic x,
                          input logic [VW-1:0] va);
    req_valid[l] = 1'b1;
    req_kernel[l] = k;
    req_user[l] = u;
    req_exec[l] = x;
    req_va[l*VW +: VW] = va;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; smep_en = 1'b0; smap_en = 1'b0;
    clr_in();
    repeat (2) step();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_ac", 64'(ac), 64'd0);
    check("rst_syn_valid", 64'(syn_valid), 64'd0);
    check("rst_cnts", 64'({smep_cnt, smap_cnt}), 64'd0);
    rst_n = 1'b1;

    // SMEP fault on lane 0
    smep_en = 1'b1; smap_en = 1'b1;
    set_lane(0, 1'b1, 1'b1, 1'b1, 48'h7f00_1000);
    step();
    check("smep_rsp_valid", 64'(rsp_valid), 64'd1);
    check("smep_rsp_fault", 64'(rsp_fault), 64'd1);
    check("smep_syn_valid", 64'(syn_valid), 64'd1);
    check("smep_syn_port", 64'(syn_port), 64'd0);
    check("smep_syn_cause", 64'(syn_cause), 64'd0);
    check("smep_syn_va", 64'(syn_va), 64'h7f00_1000);
    check("smep_syn_ovf", 64'(syn_ovf), 64'd0);
    check("smep_cnt", 64'(smep_cnt), 64'd1);
    check("smep_smap_cnt", 64'(smap_cnt), 64'd0);

    clr_in(); syn_clear = 1'b1; cnt_clear = 1'b1;
    step();
    check("clr_syn_valid", 64'(syn_valid), 64'd0);
    check("clr_syn_va", 64'(syn_va), 64'd0);
    check("clr_smep_cnt", 64'(smep_cnt), 64'd0);
    check("clr_rsp_valid", 64'(rsp_valid), 64'd0);

    // SMAP override: STAC, access, CLAC+access (old AC), access
    clr_in(); stac = 1'b1;
    step();
    check("stac_ac", 64'(ac), 64'd1);
    clr_in(); set_lane(0, 1'b1, 1'b1, 1'b0, 48'h1000);
    step();
    check("ac_access_fault", 64'(rsp_fault), 64'd0);
    clr_in(); clac = 1'b1; set_lane(0, 1'b1, 1'b1, 1'b0, 48'h1000);
    step();
    check("clac_cycle_fault", 64'(rsp_fault), 64'd0);
    check("clac_ac", 64'(ac), 64'd0);
    check("clac_syn_valid", 64'(syn_valid), 64'd0);
    clr_in(); set_lane(0, 1'b1, 1'b1, 1'b0, 48'h1000);
    step();
    check("smap_fault", 64'(rsp_fault), 64'd1);
    check("smap_syn_cause", 64'(syn_cause), 64'd1);
    check("smap_syn_va", 64'(syn_va), 64'h1000);
    check("smap_cnt", 64'(smap_cnt), 64'd1);

    // STAC and CLAC together with AC=1
    clr_in(); stac = 1'b1;
    step();
    check("stac2_ac", 64'(ac), 64'd1);
    clr_in(); stac = 1'b1; clac = 1'b1;
    step();
    check("both_ac", 64'(ac), 64'd0);

    clr_in(); syn_clear = 1'b1; cnt_clear = 1'b1;
    step();
    check("clr2_syn_valid", 64'(syn_valid), 64'd0);
    check("clr2_smap_cnt", 64'(smap_cnt), 64'd0);

    // Lanes 0 (SMEP) and 1 (SMAP) fault together
    clr_in();
    set_lane(0, 1'b1, 1'b1, 1'b1, 48'hA000);
    set_lane(1, 1'b1, 1'b1, 1'b0, 48'hB000);
    step();
    check("multi_rsp_fault", 64'(rsp_fault), 64'd3);
    check("multi_syn_port", 64'(syn_port), 64'd0);
    check("multi_syn_va", 64'(syn_va), 64'hA000);
    check("multi_syn_cause", 64'(syn_cause), 64'd0);
    check("multi_syn_ovf", 64'(syn_ovf), 64'd1);
    check("multi_total", 64'(smep_cnt) + 64'(smap_cnt), 64'd2);

    clr_in(); set_lane(1, 1'b1, 1'b1, 1'b1, 48'hC000);
    step();
    check("held_syn_port", 64'(syn_port), 64'd0);
    check("held_syn_va", 64'(syn_va), 64'hA000);
    check("held_syn_ovf", 64'(syn_ovf), 64'd1);
    check("held_smep_cnt", 64'(smep_cnt), 64'd2);

    // Clear together with a lane-1 fault
    clr_in(); syn_clear = 1'b1; set_lane(1, 1'b1, 1'b1, 1'b0, 48'hD000);
    step();
    check("clrf_syn_valid", 64'(syn_valid), 64'd1);
    check("clrf_syn_port", 64'(syn_port), 64'd1);
    check("clrf_syn_va", 64'(syn_va), 64'hD000);
    check("clrf_syn_cause", 64'(syn_cause), 64'd1);
    check("clrf_syn_ovf", 64'(syn_ovf), 64'd0);

    // Non-faulting accesses: user-mode fetch, supervisor page data
    clr_in();
    set_lane(0, 1'b0, 1'b1, 1'b1, 48'h1);
    set_lane(1, 1'b1, 1'b0, 1'b0, 48'h2);
    step();
    check("nf_rsp_valid", 64'(rsp_valid), 64'd3);
    check("nf_rsp_fault", 64'(rsp_fault), 64'd0);
    check("nf_syn_ovf", 64'(syn_ovf), 64'd0);

    // SMEP disabled: kernel fetch of user page is allowed
    smep_en = 1'b0;
    clr_in(); set_lane(0, 1'b1, 1'b1, 1'b1, 48'h3);
    step();
    check("smep_off_fault", 64'(rsp_fault), 64'd0);
    smep_en = 1'b1;

    // Counter saturation at 3, then clear together with two faults
    clr_in(); cnt_clear = 1'b1;
    step();
    check("sat_start", 64'({smep_cnt, smap_cnt}), 64'd0);
    for (int i = 0; i < 5; i++) begin
      clr_in(); set_lane(0, 1'b1, 1'b1, 1'b0, 48'h5000);
      step();
      if (i == 1) check("sat_two", 64'(smap_cnt), 64'd2);
    end
    check("sat_five", 64'(smap_cnt), 64'd3);
    clr_in(); cnt_clear = 1'b1;
    set_lane(0, 1'b1, 1'b1, 1'b0, 48'h6000);
    set_lane(1, 1'b1, 1'b1, 1'b0, 48'h7000);
    step();
    check("clr_load_smap", 64'(smap_cnt), 64'd2);
    check("clr_load_smep", 64'(smep_cnt), 64'd0);

    // Reset while a faulting request is in flight
    clr_in(); stac = 1'b1;
    step();
    clr_in(); set_lane(0, 1'b1, 1'b1, 1'b1, 48'h8000);
    #2 rst_n = 1'b0;
    step();
    check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mrst_rsp_fault", 64'(rsp_fault), 64'd0);
    check("mrst_ac", 64'(ac), 64'd0);
    check("mrst_syn", 64'({syn_valid, syn_ovf, syn_port, syn_cause}), 64'd0);
    check("mrst_syn_va", 64'(syn_va), 64'd0);
    check("mrst_cnts", 64'({smep_cnt, smap_cnt}), 64'd0);
    clr_in(); rst_n = 1'b1;
    step();
    check("post_rst_valid", 64'(rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
